opcode_issue: RTL and testbench

OPCODE_ISSUE -- requirements
Module: opcode_issue

---
 rtl/opcode_issue_pkg.sv | 18 +
 rtl/opcode_issue_byte_fifo.sv | 57 +++++
 rtl/opcode_issue.sv | 104 ++++++++++
 tb/tb_opcode_issue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/opcode_issue_pkg.sv
// Shared fetch-FSM encoding, defaults and small helpers for the opcode prefetch/issue block.
package opcode_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  localparam int          DEF_DEPTH    = 4;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;
  localparam logic [7:0]  OPC_EMPTY    = 8'h00;

  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/opcode_issue_byte_fifo.sv
// Prefetch byte FIFO: push/pop/flush with occupancy count; head reads OPC_EMPTY when empty.
module byte_fifo
  import opcode_issue_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [7:0]               i_din,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [7:0]               o_head,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  // Storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_head  = o_empty ? OPC_EMPTY : r_mem[r_rd_ptr];

endmodule

// File: rtl/opcode_issue.sv
// Opcode prefetch and issue: byte fetcher feeding a small FIFO whose head is presented to microcode.
//   state | meaning
//   IDLE  | no request outstanding; issue when a FIFO slot is free
//   WAIT  | request outstanding, returned byte will be pushed
//   DROP  | request outstanding after a redirect, returned byte is discarded
module opcode_issue
  import opcode_issue_pkg::*;
#(
  parameter int          DEPTH    = DEF_DEPTH,
  parameter logic [15:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mc__more,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  oi__opcode,
  output logic [15:0] oi__pc,
  output logic        oi__stall
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_state_t  r_state;
  fetch_state_t  w_state_nxt;
  logic [15:0]   r_fetch_pc;
  logic [15:0]   r_mem_addr;
  logic [15:0]   r_pc;
  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;

  assign oi__stall = !mc__more && (w_empty || redirect_valid);
  assign w_pop     = !mc__more && !w_empty && !redirect_valid;
  assign w_push    = (r_state == ST_WAIT) && mem_ack && !redirect_valid;
  // A same-cycle pop frees a slot, so a full FIFO being drained keeps fetching.
  assign w_issue   = (r_state == ST_IDLE) && !redirect_valid &&
                     ((w_count < FULL_COUNT) || w_pop);

  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        mem_req = 1'b1;
        if (mem_ack)             w_state_nxt = ST_IDLE;
        else if (redirect_valid) w_state_nxt = ST_DROP;
      end
      ST_DROP: begin
        mem_req = 1'b1;
        if (mem_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_pc       <= RESET_PC;
      r_mem_addr <= 16'h0000;
    end else begin
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
        r_pc       <= redirect_pc;
      end else begin
        if (w_push) r_fetch_pc <= pc_inc(r_fetch_pc);
        if (w_pop)  r_pc       <= pc_inc(r_pc);
      end
      if (w_issue) r_mem_addr <= r_fetch_pc;
    end
  end

  assign mem_addr = r_mem_addr;
  assign oi__pc   = r_pc;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (mem_rdata),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_count (w_count),
    .o_head  (oi__opcode),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_opcode_issue.sv
// Self-checking bench for opcode_issue: vector table, directed corner sequences, random run against a queue model.
module tb_opcode_issue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mc__more;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [7:0]  oi__opcode;
  logic [15:0] oi__pc;
  logic        oi__stall;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] f_byte(input logic [15:0] a);
    return a[7:0] + 8'hA0;
  endfunction

  // Memory contents are a fixed function of address.
  assign mem_rdata = f_byte(mem_addr);

  opcode_issue #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .mc__more       (mc__more),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .oi__opcode     (oi__opcode),
    .oi__pc         (oi__pc),
    .oi__stall      (oi__stall)
  );

  // Reference model: queue of prefetched byte addresses plus one outstanding request.
  logic [15:0] m_q[$];
  logic [15:0] m_pc, m_fpc, m_addr;
  bit          m_busy, m_drop;

  logic        s_req, s_stall;
  logic [15:0] s_addr, s_pc;
  logic [7:0]  s_op;

  typedef struct {
    logic        mc;
    logic        rd;
    logic [15:0] rpc;
    logic        ak;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_stall;
    logic [7:0]  e_op;
    logic [15:0] e_pc;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc   = 16'h0000;
    m_fpc  = 16'h0000;
    m_addr = 16'h0000;
    m_busy = 0;
    m_drop = 0;
  endtask

  // Called at a falling edge with reset released; leaves the bench at the next falling edge.
  task automatic do_reset();
    rst = 1'b1;
    mc__more = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic mc, input logic rd, input logic [15:0] rpc, input logic ak);
    bit pop;
    mc__more = mc; redirect_valid = rd; redirect_pc = rpc; mem_ack = ak;
    #1;
    s_req = mem_req; s_addr = mem_addr; s_stall = oi__stall; s_op = oi__opcode; s_pc = oi__pc;
    chk("mem_req",   mem_req,   m_busy);
    chk("mem_addr",  mem_addr,  m_addr);
    chk("oi_stall",  oi__stall, !mc && (m_q.size() == 0 || rd));
    chk("oi_opcode", oi__opcode, (m_q.size() > 0) ? f_byte(m_q[0]) : 8'h00);
    chk("oi_pc",     oi__pc,    m_pc);
    if (rd) begin
      m_q.delete();
      m_pc  = rpc;
      m_fpc = rpc;
      if (m_busy && !ak) m_drop = 1;
      else begin m_busy = 0; m_drop = 0; end
    end else begin
      pop = !mc && (m_q.size() > 0);
      if (pop) begin
        void'(m_q.pop_front());
        m_pc = m_pc + 16'd1;
      end
      if (m_busy) begin
        if (ak) begin
          if (!m_drop) begin
            m_q.push_back(m_addr);
            m_fpc = m_fpc + 16'd1;
          end
          m_busy = 0;
          m_drop = 0;
        end
      end else if (m_q.size() < DEPTH) begin
        m_busy = 1;
        m_addr = m_fpc;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill from reset with zero-wait memory while microcode is busy, then drain four.
    tbl[0]  = '{1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h0000};
    tbl[2]  = '{1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'hA0, 16'h0000};
    tbl[3]  = '{1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0001, 1'b0, 8'hA0, 16'h0000};
    tbl[4]  = '{1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0001, 1'b0, 8'hA0, 16'h0000};
    tbl[5]  = '{1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0002, 1'b0, 8'hA0, 16'h0000};
    tbl[6]  = '{1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0002, 1'b0, 8'hA0, 16'h0000};
    tbl[7]  = '{1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0003, 1'b0, 8'hA0, 16'h0000};
    tbl[8]  = '{1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0003, 1'b0, 8'hA0, 16'h0000};
    tbl[9]  = '{1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0003, 1'b0, 8'hA0, 16'h0000};
    tbl[10] = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0003, 1'b0, 8'hA0, 16'h0000};
    tbl[11] = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0004, 1'b0, 8'hA1, 16'h0001};
    tbl[12] = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0004, 1'b0, 8'hA2, 16'h0002};
    tbl[13] = '{1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0005, 1'b0, 8'hA3, 16'h0003};

    rst = 1'b1;
    mc__more = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0; mem_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_stall",   oi__stall, 1'b1);
    chk("rst_opcode",  oi__opcode, 8'h00);
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      mc__more = tbl[i].mc; redirect_valid = tbl[i].rd; redirect_pc = tbl[i].rpc; mem_ack = tbl[i].ak;
      #1;
      chk($sformatf("tbl%0d_req", i),   mem_req,    tbl[i].e_req);
      chk($sformatf("tbl%0d_addr", i),  mem_addr,   tbl[i].e_addr);
      chk($sformatf("tbl%0d_stall", i), oi__stall,  tbl[i].e_stall);
      chk($sformatf("tbl%0d_op", i),    oi__opcode, tbl[i].e_op);
      chk($sformatf("tbl%0d_pc", i),    oi__pc,     tbl[i].e_pc);
      @(negedge clk);
    end

    // Slow memory with microcode waiting: stall until the first byte lands.
    do_reset();
    step(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      chk("slow_stall", s_stall, 1'b1);
    end
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("slow_stall_push", s_stall, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("slow_stall_off", s_stall, 1'b0);
    chk("slow_first_op", s_op, 8'hA0);

    // Redirect while a fetch is outstanding; stale byte dropped.
    do_reset();
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h1234, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("drop_req_held", s_req, 1'b1);
    chk("drop_addr_old", s_addr, 16'h0000);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("redir_addr", s_addr, 16'h1234);
    chk("redir_pc", s_pc, 16'h1234);
    chk("redir_no_stale", s_op, 8'h00);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("redir_first_op", s_op, 8'hD4);

    // Redirect colliding with ack and a would-be consume.
    do_reset();
    step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b1, 16'h0050, 1'b1);
    chk("coll_stall", s_stall, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("coll_empty", s_op, 8'h00);
    chk("coll_pc", s_pc, 16'h0050);
    chk("coll_stall_after", s_stall, 1'b1);

    // Address wrap at FFFF, then reset in the middle of a fetch.
    do_reset();
    step(1'b1, 1'b1, 16'hFFFF, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("wrap_addr_ffff", s_addr, 16'hFFFF);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("wrap_addr_0000", s_addr, 16'h0000);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    mem_ack = 1'b0;
    #1;
    chk("midwait_req", mem_req, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_req_drop", mem_req, 1'b0);
    chk("async_pc", oi__pc, 16'h0000);
    chk("async_opcode", oi__opcode, 8'h00);
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    chk("restart_addr", s_addr, 16'h0000);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic        r_mc, r_rd, r_ak;
      logic [15:0] r_pc;
      r_mc = ($urandom_range(0, 99) < 45);
      r_rd = ($urandom_range(0, 99) < 5);
      r_ak = ($urandom_range(0, 99) < 60);
      r_pc = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFD + $urandom_range(0, 2)) : 16'($urandom);
      step(r_mc, r_rd, r_pc, r_ak);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
